// File: rtl/noc_port_adapter.sv
// Per-lane ingress/egress FIFOs between NetEmulation nodes and the ENoC core.
// Ingress gives nodes real backpressure; egress gives the network a real i_en.
module noc_port_adapter #(
    parameter int PORTS     = 16,
    parameter int PKT_W     = 64,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 2,
    parameter int NF_THRESH = IN_DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [PORTS*PKT_W-1:0] node_pkt_in,
    input  logic [PORTS-1:0]       node_val_in,
    output logic [PORTS-1:0]       net_full,
    output logic [PORTS-1:0]       nearly_full,
    output logic [PORTS-1:0]       overflow,
    output logic [PORTS*PKT_W-1:0] net_data_out,
    output logic [PORTS-1:0]       net_val_out,
    input  logic [PORTS-1:0]       net_en_in,
    input  logic [PORTS*PKT_W-1:0] net_data_in,
    input  logic [PORTS-1:0]       net_val_in,
    output logic [PORTS-1:0]       net_en_out,
    output logic [PORTS*PKT_W-1:0] node_pkt_out,
    output logic [PORTS-1:0]       node_val_out,
    input  logic [PORTS-1:0]       node_rdy_in
);

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int ICW = IAW + 1;
    localparam int OCW = OAW + 1;
    localparam logic [ICW-1:0] IFULL = ICW'(IN_DEPTH);
    localparam logic [ICW-1:0] INF   = ICW'(NF_THRESH);
    localparam logic [OCW-1:0] OFULL = OCW'(OUT_DEPTH);

    for (genvar i = 0; i < PORTS; i++) begin : g_lane
        logic [PKT_W-1:0] imem [IN_DEPTH];
        logic [IAW-1:0]   iwp, irp;
        logic [ICW-1:0]   icnt;
        logic             ipush, ipop, ovf;

        logic [PKT_W-1:0] emem [OUT_DEPTH];
        logic [OAW-1:0]   ewp, erp;
        logic [OCW-1:0]   ecnt;
        logic             epush, epop, een;

        // Acceptance looks only at registered icnt, never at net_en_in
        assign ipush = node_val_in[i] && (icnt != IFULL);
        assign ipop  = (icnt != '0) && net_en_in[i];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                iwp  <= '0;
                irp  <= '0;
                icnt <= '0;
                ovf  <= 1'b0;
            end else begin
                if (ipush) iwp <= iwp + 1'b1;
                if (ipop)  irp <= irp + 1'b1;
                icnt <= icnt + ICW'(ipush) - ICW'(ipop);
                if (node_val_in[i] && icnt == IFULL) ovf <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (ipush) imem[iwp] <= node_pkt_in[i*PKT_W +: PKT_W];
        end

        assign net_val_out[i]                = ipop;
        assign net_data_out[i*PKT_W +: PKT_W] = imem[irp];
        assign net_full[i]                   = (icnt == IFULL);
        assign nearly_full[i]                = (icnt >= INF);
        assign overflow[i]                   = ovf;

        assign een   = (ecnt < OFULL);
        assign epush = net_val_in[i] && een;
        assign epop  = (ecnt != '0) && node_rdy_in[i];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ewp  <= '0;
                erp  <= '0;
                ecnt <= '0;
            end else begin
                if (epush) ewp <= ewp + 1'b1;
                if (epop)  erp <= erp + 1'b1;
                ecnt <= ecnt + OCW'(epush) - OCW'(epop);
            end
        end

        always_ff @(posedge clk) begin
            if (epush) emem[ewp] <= net_data_in[i*PKT_W +: PKT_W];
        end

        assign net_en_out[i]                  = een;
        assign node_val_out[i]                = (ecnt != '0);
        assign node_pkt_out[i*PKT_W +: PKT_W] = emem[erp];

        // The network must never offer a packet while we withhold enable
        a_egress_proto: assert property (
            @(posedge clk) disable iff (!reset_n) net_val_in[i] |-> een
        );
    end

endmodule

// File: tb/tb_noc_port_adapter.sv
// Directed bench for noc_port_adapter: lane 0 exercised against a count
// model plus packet queues, remaining lanes held idle.
module tb_noc_port_adapter;

    localparam int PORTS = 16;
    localparam int PKT_W = 64;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [PORTS*PKT_W-1:0] node_pkt_in;
    logic [PORTS-1:0]       node_val_in;
    logic [PORTS-1:0]       net_full;
    logic [PORTS-1:0]       nearly_full;
    logic [PORTS-1:0]       overflow;
    logic [PORTS*PKT_W-1:0] net_data_out;
    logic [PORTS-1:0]       net_val_out;
    logic [PORTS-1:0]       net_en_in;
    logic [PORTS*PKT_W-1:0] net_data_in;
    logic [PORTS-1:0]       net_val_in;
    logic [PORTS-1:0]       net_en_out;
    logic [PORTS*PKT_W-1:0] node_pkt_out;
    logic [PORTS-1:0]       node_val_out;
    logic [PORTS-1:0]       node_rdy_in;

    noc_port_adapter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .node_pkt_in  (node_pkt_in),
        .node_val_in  (node_val_in),
        .net_full     (net_full),
        .nearly_full  (nearly_full),
        .overflow     (overflow),
        .net_data_out (net_data_out),
        .net_val_out  (net_val_out),
        .net_en_in    (net_en_in),
        .net_data_in  (net_data_in),
        .net_val_in   (net_val_in),
        .net_en_out   (net_en_out),
        .node_pkt_out (node_pkt_out),
        .node_val_out (node_val_out),
        .node_rdy_in  (node_rdy_in)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          m_icnt = 0;
    int          m_ecnt = 0;
    logic        m_ovf  = 1'b0;
    logic [63:0] iq [$];
    logic [63:0] eq [$];
    logic        last_eacc;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check lane 0 against the model, advance the model, step one edge
    task automatic tick();
        logic ipop, ipush, epop, epush;
        #1;
        ipop  = (m_icnt != 0) && net_en_in[0];
        ipush = node_val_in[0] && (m_icnt < 4);
        epush = net_val_in[0] && (m_ecnt < 2);
        epop  = (m_ecnt != 0) && node_rdy_in[0];
        chk("net_val", 64'(net_val_out[0]), 64'(ipop));
        if (!net_en_in[0]) chk("voq_gate", 64'(net_val_out[0]), 64'd0);
        chk("net_full", 64'(net_full[0]), 64'(m_icnt == 4));
        chk("nearly_full", 64'(nearly_full[0]), 64'(m_icnt >= 3));
        chk("overflow", 64'(overflow[0]), 64'(m_ovf));
        chk("net_en_out", 64'(net_en_out[0]), 64'(m_ecnt < 2));
        chk("node_val", 64'(node_val_out[0]), 64'(m_ecnt != 0));
        chk("idle_lanes", 64'({net_val_out[PORTS-1:1], node_val_out[PORTS-1:1],
                               overflow[PORTS-1:1], net_full[PORTS-1:1]}), 64'd0);
        if (ipop) begin
            if (iq.size() == 0) chk("iq_underrun", 64'd1, 64'd0);
            else chk("net_data", net_data_out[63:0], iq.pop_front());
        end
        if (epop) begin
            if (eq.size() == 0) chk("eq_underrun", 64'd1, 64'd0);
            else chk("node_pkt", node_pkt_out[63:0], eq.pop_front());
        end
        if (ipush) iq.push_back(node_pkt_in[63:0]);
        if (node_val_in[0] && m_icnt == 4) m_ovf = 1'b1;
        if (epush) eq.push_back(net_data_in[63:0]);
        m_icnt = m_icnt + int'(ipush) - int'(ipop);
        m_ecnt = m_ecnt + int'(epush) - int'(epop);
        last_eacc = epush;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_net_val"}, 64'(net_val_out), 64'd0);
        chk({tag, "_node_val"}, 64'(node_val_out), 64'd0);
        chk({tag, "_net_full"}, 64'(net_full), 64'd0);
        chk({tag, "_nearly_full"}, 64'(nearly_full), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_net_en_out"}, 64'(net_en_out), 64'(16'hFFFF));
    endtask

    task automatic model_reset();
        m_icnt = 0;
        m_ecnt = 0;
        m_ovf  = 1'b0;
        iq.delete();
        eq.delete();
    endtask

    initial begin
        int sent;
        reset_n     = 1'b0;
        node_pkt_in = '0;
        node_val_in = '0;
        net_en_in   = '1;
        net_data_in = '0;
        net_val_in  = '0;
        node_rdy_in = '1;
        #1;
        chk_reset_outputs("reset");
        #11 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single packet, sent the cycle after acceptance
        node_pkt_in[63:0] = 64'hA5;
        node_val_in[0]    = 1'b1;
        tick();
        node_val_in[0] = 1'b0;
        chk("single_val", 64'(net_val_out[0]), 64'd1);
        chk("single_data", net_data_out[63:0], 64'hA5);
        tick();
        tick();

        // Fill to full with the network blocked, then overflow
        net_en_in[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            node_pkt_in[63:0] = 64'(k);
            node_val_in[0]    = 1'b1;
            tick();
            if (k == 3) chk("nf_after_3", 64'(nearly_full[0]), 64'd1);
            if (k == 3) chk("full_after_3", 64'(net_full[0]), 64'd0);
            if (k == 4) chk("full_after_4", 64'(net_full[0]), 64'd1);
        end
        node_val_in[0] = 1'b0;
        chk("ovf_after_5", 64'(overflow[0]), 64'd1);
        net_en_in[0] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("fill_drained", 64'(iq.size()), 64'd0);

        // Enable toggling while packets trickle in
        for (int c = 0; c < 12; c++) begin
            net_en_in[0]      = c[0];
            node_val_in[0]    = (c % 3 != 2);
            node_pkt_in[63:0] = 64'h100 + 64'(c);
            tick();
        end
        node_val_in[0] = 1'b0;
        net_en_in[0]   = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("voq_drained", 64'(iq.size()), 64'd0);

        // Streaming at occupancy 2 across several pointer wraps
        net_en_in[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            node_pkt_in[63:0] = 64'h200 + 64'(k);
            node_val_in[0]    = 1'b1;
            tick();
        end
        net_en_in[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            node_pkt_in[63:0] = 64'h300 + 64'(k);
            tick();
        end
        node_val_in[0] = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("stream_drained", 64'(iq.size()), 64'd0);

        // Egress backpressure: 3 packets offered into a 2-deep FIFO
        node_rdy_in[0] = 1'b0;
        sent = 0;
        for (int c = 0; c < 8 && sent < 2; c++) begin
            net_val_in[0]     = (m_ecnt < 2);
            net_data_in[63:0] = 64'hE0 + 64'(sent);
            tick();
            if (last_eacc) sent++;
        end
        net_val_in[0] = 1'b0;
        chk("eg_en_low", 64'(net_en_out[0]), 64'd0);
        tick();
        tick();
        node_rdy_in[0] = 1'b1;
        for (int c = 0; c < 10 && sent < 3; c++) begin
            net_val_in[0]     = (m_ecnt < 2);
            net_data_in[63:0] = 64'hE0 + 64'(sent);
            tick();
            if (last_eacc) sent++;
        end
        net_val_in[0] = 1'b0;
        chk("eg_sent3", 64'(sent), 64'd3);
        for (int k = 0; k < 4; k++) tick();
        chk("eg_drained", 64'(eq.size()), 64'd0);

        // Mid-stream reset with two packets in each FIFO
        net_en_in[0]   = 1'b0;
        node_rdy_in[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            node_val_in[0]    = 1'b1;
            node_pkt_in[63:0] = 64'h400 + 64'(k);
            net_val_in[0]     = 1'b1;
            net_data_in[63:0] = 64'h500 + 64'(k);
            tick();
        end
        node_val_in[0] = 1'b0;
        net_val_in[0]  = 1'b0;
        chk("pre_rst_node_val", 64'(node_val_out[0]), 64'd1);
        chk("pre_rst_en_out", 64'(net_en_out[0]), 64'd0);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        net_en_in[0]   = 1'b1;
        node_rdy_in[0] = 1'b1;
        for (int k = 0; k < 4; k++) tick();

        // Full FIFO with a concurrent pop still drops the push
        net_en_in[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            node_val_in[0]    = 1'b1;
            node_pkt_in[63:0] = 64'h600 + 64'(k);
            tick();
        end
        net_en_in[0]      = 1'b1;
        node_pkt_in[63:0] = 64'h6FF;
        tick();
        node_val_in[0] = 1'b0;
        chk("ovf_with_pop", 64'(overflow[0]), 64'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("final_drained", 64'(iq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/noc_port_adapter.md
# noc_port_adapter

Parametrised per-port adapter between the NetEmulation traffic nodes and the ENoC network core. It replaces direct wiring with an ingress FIFO and an egress FIFO per port. This gives NetEmulation real `net_full`/`nearly_full` backpressure instead of a tied-off `net_full`, and gives the network a real `i_en` instead of a constant `'1`. The adapter sits between the NetEmulation node array and the `network` instance, one lane per port.

## Interface
- `PORTS`, 16: number of node/network lanes.
- `PKT_W`, 64: packet width in bits; the valid flag is carried separately.
- `IN_DEPTH`, 4: ingress FIFO entries per port; power of two, at least 2.
- `OUT_DEPTH`, 2: egress FIFO entries per port; power of two, at least 2.
- `NF_THRESH`, `IN_DEPTH`-1: ingress occupancy at which `nearly_full` asserts; range 1..`IN_DEPTH`.

- `clk`  in  1  single clock; all state on its rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `node_pkt_in`  in  `PORTS`*`PKT_W`  packets from the nodes; lane i occupies bits [i*PKT_W +: PKT_W].
- `node_val_in`  in  `PORTS`  node packet valid.
- `net_full`  out  `PORTS`  ingress FIFO full.
- `nearly_full`  out  `PORTS`  ingress occupancy ≥ `NF_THRESH`.
- `overflow`  out  `PORTS`  sticky flag: a packet was dropped because the FIFO was full.
- `net_data_out`  out  `PORTS`*`PKT_W`  packets to `network.i_data`.
- `net_val_out`  out  `PORTS`  drives `network.i_data_val`.
- `net_en_in`  in  `PORTS`  from `network.o_en`.
- `net_data_in`  in  `PORTS`*`PKT_W`  from `network.o_data`.
- `net_val_in`  in  `PORTS`  from `network.o_data_val`.
- `net_en_out`  out  `PORTS`  drives `network.i_en`.
- `node_pkt_out`  out  `PORTS`*`PKT_W`  packets to the nodes.
- `node_val_out`  out  `PORTS`  node packet valid.
- `node_rdy_in`  in  `PORTS`  node can accept a packet; tie to '1 for legacy always-ready nodes.

## Operation
- Lanes are fully independent; behaviour below is per lane i.
- Ingress FIFO:
  - Circular buffer with rd/wr pointers and an occupancy count `icnt` of width clog2(`IN_DEPTH`)+1.
  - Push when `node_val_in` and `icnt` < `IN_DEPTH`. Acceptance depends only on registered `icnt`; there is no combinational path from `net_en_in`.
  - A push attempted while `icnt` == `IN_DEPTH` is dropped and sets `overflow`. The flag clears only on reset. This holds even when a pop happens in the same cycle.
- Network send (VOQ rule):
  - `net_val_out` = (`icnt` != 0) && `net_en_in`. Valid is never raised without enable.
  - `net_data_out` = head entry (first-word fall-through).
  - Pop when `net_val_out` is high.
- Simultaneous push and pop with 0 < `icnt` < `IN_DEPTH`: count unchanged, both pointers advance.
- `net_full` = (`icnt` == `IN_DEPTH`); `nearly_full` = (`icnt` ≥ `NF_THRESH`). Both are combinational from registered `icnt`.
- Egress FIFO:
  - Count `ecnt`.
  - `net_en_out` = (`ecnt` < `OUT_DEPTH`), combinational from registered state.
  - Push when `net_val_in` && `net_en_out`. If `net_val_in` arrives with `net_en_out` low, it is ignored (a network protocol violation, flagged by an assertion only).
- Node delivery:
  - `node_val_out` = (`ecnt` != 0); `node_pkt_out` = head entry.
  - Pop when `node_val_out` && `node_rdy_in`.
- Pointers wrap modulo depth; the power-of-two depth makes the wrap a natural overflow of the pointer bits.

## Timing
- Reset (asynchronous, `reset_n` low):
  - Pointers and counts clear to 0; `overflow`=0.
  - Outputs during reset: `net_full`=0, `nearly_full`=0, `net_val_out`=0, `node_val_out`=0, `net_en_out`=1.
  - FIFO data storage is not reset; data outputs are don't-care while the matching valid is 0.
- Reset asserted mid-transfer discards all buffered packets immediately. Operation resumes on the first rising edge after deassertion.
- Ingress latency: a packet accepted at edge N is visible on `net_data_out` after edge N, so it can be sent in cycle N+1 at the earliest.
- `net_full`/`nearly_full` reflect pushes and pops of edge N from cycle N+1; there is a 1-cycle feedback delay.
- Egress latency: a packet accepted at edge N gives `node_val_out`=1 in cycle N+1.
- Throughput: 1 packet per cycle per direction when unblocked. A full FIFO with a concurrent pop does not accept a push in that cycle.

## Test plan
- Reset, then single packet: `node_pkt_in` lane 0 = 0xA5, `node_val_in`=1 for one cycle, `net_en_in`=1 → `net_val_out[0]`=1 with 0xA5 exactly one cycle later, then `icnt` back to 0; all other lanes stay idle.
- Fill with `net_en_in`=0, `IN_DEPTH`=4, pushes 1..4:
  - `nearly_full` rises the cycle after push 3; `net_full` rises the cycle after push 4.
  - A 5th push is dropped and `overflow[0]`=1.
  - Releasing `net_en_in` then drains 1,2,3,4 in order on consecutive cycles.
- VOQ gating: FIFO non-empty and `net_en_in` toggled 1/0 → `net_val_out` never high while `net_en_in`=0, and no packet is lost or duplicated.
- Steady streaming: push and pop every cycle for 20 cycles at occupancy 2 → `icnt` constant, output sequence equals input sequence, and the pointers wrap correctly past index 3.
- Egress backpressure: `node_rdy_in`=0 while network sends 3 packets →
  - `net_en_out` drops after 2 accepted; the 3rd is held by the network.
  - Raising `node_rdy_in` delivers all 3 in order.
- Mid-stream reset with both FIFOs at 2 entries → all valids 0 and `net_en_out`=1 immediately; no stale packet appears after release.
